// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: two-stage pipelined text-mode pixel generator.
//   Stage 1 looks up the glyph bit for (ascii,row,col) and registers it with the
//   attribute, blank flag, cursor hit and both blink phases. Stage 2 applies
//   attribute blink, cursor inversion and blanking, and registers the colour.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid                  ascii/attr/row/col/blank/cursor_here valid this cycle
//   ascii, attr, row, col     character cell and glyph position
//   blank                     pixel outside the active area (forces rgb=0)
//   cursor_here, cursor_en    cursor cell flag and global cursor enable
//   cur_start, cur_end        inclusive glyph-row range of the cursor
//   frame_tick                one-cycle pulse per frame, drives the blink counters
//   out_valid, rgb            registered pixel colour, 2 cycles after in_valid
// Also contains font_lut, the combinational 8x16 glyph ROM used by stage 1.

// font_lut: 8x16 glyph bit lookup; col 0 is the leftmost pixel (bit 7 of a row).
//   ascii, row, col   character and glyph position
//   px_c              glyph bit (combinational)
module font_lut (
    input  logic [7:0] ascii,
    input  logic [3:0] row,
    input  logic [2:0] col,
    output logic       px_c
);

    logic [7:0] bits_c;
    logic [7:0] box_c;

    // Hollow box used for every code without a dedicated glyph.
    always_comb begin
        box_c = 8'h00;
        if (row == 4'd1 || row == 4'd14) begin
            box_c = 8'h7E;
        end else if (row >= 4'd2 && row <= 4'd13) begin
            box_c = 8'h42;
        end
    end

    // Row bitmap for the selected character.
    always_comb begin
        bits_c = 8'h00;
        case (ascii)
            8'h00, 8'h20: bits_c = 8'h00;
            8'h41: begin
                case (row)
                    4'd2:                      bits_c = 8'h10;
                    4'd3:                      bits_c = 8'h38;
                    4'd4:                      bits_c = 8'h6C;
                    4'd5, 4'd6:                bits_c = 8'hC6;
                    4'd7:                      bits_c = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11:  bits_c = 8'hC6;
                    default:                   bits_c = 8'h00;
                endcase
            end
            8'h2B: begin
                if (row == 4'd7) begin
                    bits_c = 8'hFE;
                end else if (row >= 4'd4 && row <= 4'd10) begin
                    bits_c = 8'h10;
                end
            end
            8'h5F: bits_c = (row == 4'd14) ? 8'hFF : 8'h00;
            8'hB0: bits_c = row[0] ? 8'hAA : 8'h55;
            8'hC4: bits_c = (row == 4'd7) ? 8'hFF : 8'h00;
            8'hDB: bits_c = 8'hFF;
            // Upper half of the code page shows the inverted box so it stands apart.
            default: bits_c = ascii[7] ? ~box_c : box_c;
        endcase
    end

    assign px_c = bits_c[3'd7 - col];

endmodule

module text_pixel_pipe #(
    parameter int unsigned RGB_W         = 3,
    parameter int unsigned BLINK_EN      = 1,
    parameter int unsigned BLINK_FRAMES  = 32,
    parameter int unsigned CURSOR_FRAMES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       ascii,
    input  logic [7:0]       attr,
    input  logic [3:0]       row,
    input  logic [2:0]       col,
    input  logic             blank,
    input  logic             cursor_here,
    input  logic             cursor_en,
    input  logic [3:0]       cur_start,
    input  logic [3:0]       cur_end,
    input  logic             frame_tick,
    output logic             out_valid,
    output logic [RGB_W-1:0] rgb
);

    localparam int unsigned BCW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int unsigned CCW = (CURSOR_FRAMES > 1) ? $clog2(CURSOR_FRAMES) : 1;
    localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_FRAMES - 1);
    localparam logic [CCW-1:0] CURSOR_LAST = CCW'(CURSOR_FRAMES - 1);
    localparam logic           BLINK_ON    = (BLINK_EN != 0);

    typedef struct packed {
        logic       px;
        logic [7:0] attr;
        logic       blank;
        logic       hit;
        logic       bphase;
        logic       cphase;
    } s1_t;

    logic [BCW-1:0] blink_cnt;
    logic [CCW-1:0] cursor_cnt;
    logic           blink_phase;
    logic           cursor_phase;

    logic           px_c;
    logic           hit_c;
    s1_t            s1_next_c;
    s1_t            s1;
    logic           s1_valid;

    logic           on_c;
    logic [3:0]     colour_c;

    font_lut u_font (
        .ascii (ascii),
        .row   (row),
        .col   (col),
        .px_c  (px_c)
    );

    // Free-running frame counters; each phase toggles once per half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            cursor_cnt   <= '0;
            cursor_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BCW'(1);
            end
            if (cursor_cnt == CURSOR_LAST) begin
                cursor_cnt   <= '0;
                cursor_phase <= ~cursor_phase;
            end else begin
                cursor_cnt <= cursor_cnt + CCW'(1);
            end
        end
    end

    // An inverted row range (start > end) can never satisfy both bounds.
    assign hit_c = cursor_en & cursor_here & (row >= cur_start) & (row <= cur_end);

    // Phases sampled here are the pre-tick values when frame_tick coincides.
    always_comb begin
        s1_next_c        = '0;
        s1_next_c.px     = px_c;
        s1_next_c.attr   = attr;
        s1_next_c.blank  = blank;
        s1_next_c.hit    = hit_c;
        s1_next_c.bphase = blink_phase;
        s1_next_c.cphase = cursor_phase;
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= in_valid;
            s1       <= s1_next_c;
        end
    end

    // Blink forces the glyph off first, then the cursor inverts; a blinking
    // cell under the cursor therefore shows a solid foreground bar.
    always_comb begin
        on_c = s1.px;
        if (BLINK_ON && s1.attr[7] && s1.bphase) begin
            on_c = 1'b0;
        end
        if (s1.hit && !s1.cphase) begin
            on_c = ~on_c;
        end
        if (on_c) begin
            colour_c = {s1.attr[3], s1.attr[2:0]};
        end else begin
            colour_c = {(BLINK_ON ? 1'b0 : s1.attr[7]), s1.attr[6:4]};
        end
        if (s1.blank) begin
            colour_c = 4'h0;
        end
    end

    // Stage 2 register; rgb holds its last value through invalid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rgb       <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                rgb <= RGB_W'(colour_c);
            end
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Scoreboard bench for text_pixel_pipe: two instances (3-bit blinking, 4-bit
// intensity) share one stimulus stream; expectations come from a glyph/phase
// model built on frame-tick counts, checked by a separate negedge monitor.
module tb_text_pixel_pipe;

    localparam int unsigned A_BF = 2;
    localparam int unsigned A_CF = 4;
    localparam int unsigned B_BF = 3;
    localparam int unsigned B_CF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] ascii = 8'h0;
    logic [7:0] attr = 8'h0;
    logic [3:0] row = 4'h0;
    logic [2:0] col = 3'h0;
    logic       blank = 1'b0;
    logic       cursor_here = 1'b0;
    logic       cursor_en = 1'b0;
    logic [3:0] cur_start = 4'h0;
    logic [3:0] cur_end = 4'h0;
    logic       frame_tick = 1'b0;

    logic       ov_a;
    logic [2:0] rgb_a;
    logic       ov_b;
    logic [3:0] rgb_b;

    always #5 clk = ~clk;

    text_pixel_pipe #(.RGB_W(3), .BLINK_EN(1), .BLINK_FRAMES(A_BF), .CURSOR_FRAMES(A_CF)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ascii(ascii), .attr(attr),
        .row(row), .col(col), .blank(blank), .cursor_here(cursor_here),
        .cursor_en(cursor_en), .cur_start(cur_start), .cur_end(cur_end),
        .frame_tick(frame_tick), .out_valid(ov_a), .rgb(rgb_a)
    );

    text_pixel_pipe #(.RGB_W(4), .BLINK_EN(0), .BLINK_FRAMES(B_BF), .CURSOR_FRAMES(B_CF)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ascii(ascii), .attr(attr),
        .row(row), .col(col), .blank(blank), .cursor_here(cursor_here),
        .cursor_en(cursor_en), .cur_start(cur_start), .cur_end(cur_end),
        .frame_tick(frame_tick), .out_valid(ov_b), .rgb(rgb_b)
    );

    typedef struct {
        logic [3:0] rgb;
        int         due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int cyc = 0;
    int ticks = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    string a_glyph [16] = '{
        "........", "........", "...#....", "..###...",
        ".##.##..", "##...##.", "##...##.", "#######.",
        "##...##.", "##...##.", "##...##.", "##...##.",
        "........", "........", "........", "........"
    };

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit font_px(input logic [7:0] c, input int r, input int k);
        bit inner;
        bit edge_px;
        byte ch;
        inner   = (r >= 1) && (r <= 14) && (k >= 1) && (k <= 6);
        edge_px = inner && (r == 1 || r == 14 || k == 1 || k == 6);
        case (c)
            8'h00, 8'h20: return 1'b0;
            8'h41: begin
                ch = a_glyph[r][k];
                return ch == 8'h23;
            end
            8'h2B: return (r == 7 && k <= 6) || (k == 3 && r >= 4 && r <= 10);
            8'h5F: return r == 14;
            8'hB0: return ((r + k) % 2) == 1;
            8'hC4: return r == 7;
            8'hDB: return 1'b1;
            default: return (c >= 8'h80) ? !edge_px : edge_px;
        endcase
    endfunction

    // Phase = parity of completed half-periods since reset.
    function automatic logic [3:0] model(input bit blink_en, input int bf, input int cf,
                                         input logic [7:0] c, input logic [7:0] at,
                                         input logic [3:0] r, input logic [2:0] k,
                                         input bit bl, input bit ch, input bit cen,
                                         input logic [3:0] cs, input logic [3:0] ce);
        bit on;
        bit bphase;
        bit cphase;
        bit hit;
        bphase = ((ticks / bf) % 2) == 1;
        cphase = ((ticks / cf) % 2) == 1;
        if (bl) return 4'h0;
        on = font_px(c, int'(r), int'(k));
        if (blink_en && at[7] && bphase) on = 1'b0;
        hit = cen && ch && (int'(cs) <= int'(r)) && (int'(r) <= int'(ce));
        if (hit && !cphase) on = !on;
        if (on) return {at[3], at[2:0]};
        return {(blink_en ? 1'b0 : at[7]), at[6:4]};
    endfunction

    task automatic issue(input bit v, input logic [7:0] c, input logic [7:0] at,
                         input logic [3:0] r, input logic [2:0] k, input bit bl,
                         input bit ch, input bit cen, input logic [3:0] cs,
                         input logic [3:0] ce, input bit tk);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; ascii = c; attr = at; row = r; col = k; blank = bl;
        cursor_here = ch; cursor_en = cen; cur_start = cs; cur_end = ce; frame_tick = tk;
        if (v && !rst) begin
            e.due = cyc + 2;
            e.rgb = model(1'b1, A_BF, A_CF, c, at, r, k, bl, ch, cen, cs, ce);
            q_a.push_back(e);
            e.rgb = model(1'b0, B_BF, B_CF, c, at, r, k, bl, ch, cen, cs, ce);
            q_b.push_back(e);
        end
        if (tk && !rst) ticks++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            issue(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            issue(1'b0, 8'h00, 8'h00, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        end
    endtask

    task automatic full_glyph(input logic [7:0] c, input logic [7:0] at, input bit cen,
                              input logic [3:0] cs, input logic [3:0] ce);
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 8; k++) begin
                issue(1'b1, c, at, 4'(r), 3'(k), 1'b0, 1'b1, cen, cs, ce, 1'b0);
            end
        end
    endtask

    logic [2:0] held_a = 3'h0;
    logic [3:0] held_b = 4'h0;

    // Monitor: pops the scoreboard on each valid output, checks hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("a.rst_valid", int'(ov_a), 0);
            check("a.rst_rgb", int'(rgb_a), 0);
            check("b.rst_valid", int'(ov_b), 0);
            check("b.rst_rgb", int'(rgb_b), 0);
        end else begin
            if (ov_a) begin
                if (q_a.size() == 0) begin
                    check("a.unexpected_valid", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a.rgb", int'(rgb_a), int'(e.rgb[2:0]));
                    check("a.latency_cycle", cyc, e.due);
                end
            end else begin
                check("a.rgb_hold", int'(rgb_a), int'(held_a));
            end
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    check("b.unexpected_valid", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b.rgb", int'(rgb_b), int'(e.rgb));
                    check("b.latency_cycle", cyc, e.due);
                end
            end else begin
                check("b.rgb_hold", int'(rgb_b), int'(held_b));
            end
        end
        held_a = rgb_a;
        held_b = rgb_b;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] c;
        // Power-on reset.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_a", int'(ov_a), 0);
        check("reset_rgb_b", int'(rgb_b), 0);
        rst = 1'b0;
        ticks = 0;

        // Plain glyph rendering.
        full_glyph(8'h41, 8'h1E, 1'b0, 4'd0, 4'd15);

        // Blanking, then hold through invalid cycles.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 8'hDB, 8'h7F, 4'(i), 3'(i), 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        end
        issue(1'b1, 8'hDB, 8'h7F, 4'd3, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(6);

        // Attribute blink: off after 2 ticks, back after 2 more.
        full_glyph(8'h41, 8'h9E, 1'b0, 4'd0, 4'd15);
        tick(2);
        full_glyph(8'h41, 8'h9E, 1'b0, 4'd0, 4'd15);
        tick(2);
        full_glyph(8'h41, 8'h9E, 1'b0, 4'd0, 4'd15);

        // Underline cursor, then its off phase; ticks align the cursor phase to 0 first.
        tick(4);
        full_glyph(8'h20, 8'h07, 1'b1, 4'd14, 4'd15);
        tick(A_CF);
        full_glyph(8'h20, 8'h07, 1'b1, 4'd14, 4'd15);
        full_glyph(8'h41, 8'h07, 1'b1, 4'd9, 4'd3);

        // Intensity bit with bg-intensity attribute.
        issue(1'b1, 8'h20, 8'h8F, 4'd5, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        issue(1'b1, 8'hDB, 8'h8F, 4'd5, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // Blinking cell under the cursor, with pixels coinciding with ticks.
        for (int i = 0; i < 12; i++) begin
            issue(1'b1, 8'h41, 8'h9A, 4'(i + 4), 3'(i), 1'b0, 1'b1, 1'b1, 4'd4, 4'd15, 1'b1);
        end

        // Reset with pixels in flight and phases away from zero.
        tick(3);
        issue(1'b1, 8'h41, 8'h9E, 4'd7, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        issue(1'b1, 8'h41, 8'h9E, 4'd7, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        frame_tick = 1'b0;
        q_a.delete();
        q_b.delete();
        ticks = 0;
        #1;
        check("midrst_valid_a", int'(ov_a), 0);
        check("midrst_rgb_a", int'(rgb_a), 0);
        check("midrst_valid_b", int'(ov_b), 0);
        check("midrst_rgb_b", int'(rgb_b), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        full_glyph(8'h41, 8'h9E, 1'b1, 4'd0, 4'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0: c = 8'h41;
                1: c = 8'h20;
                2: c = 8'h5F;
                3: c = 8'hDB;
                4: c = 8'h2B;
                5: c = 8'hB0;
                6: c = 8'hC4;
                default: c = 8'($urandom);
            endcase
            issue($urandom_range(0, 9) < 8, c, 8'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
        end

        idle(5);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
